accel_job_scheduler: RTL and testbench
======================================

# accel_job_scheduler

Shares one `accelerator_property`-style map/reduce engine between `NUM_REQ` requesters. Each requester submits a job as a base address plus a word count. The scheduler arbitrates round-robin, fetches the words over a single-outstanding memory read port, and drives each word through the engine's level `start`/`done` handshake. It returns the per-job count, computed as the change in the engine's cumulative total. It sits between the host-side job queues and the engine/memory fabric.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (≥2).
- `ADDR_W`, 32: byte address width.
- `LEN_W`, 16: job length field width, in words.
- `DATA_W`, `` `FE_DATA_W ``: engine and memory word width.

Ports:
- `clk_i` in 1: single clock.
- `arst_ni` in 1: reset, asynchronous and active-low.
- `req_valid_i` in NUM_REQ: job request per requester.
- `req_ready_o` out NUM_REQ: one-hot job accept.
- `req_addr_i` in NUM_REQ*ADDR_W: packed base addresses, word-aligned.
- `req_len_i` in NUM_REQ*LEN_W: packed word counts.
- `rsp_valid_o` out NUM_REQ: one-hot result valid.
- `rsp_ready_i` in NUM_REQ: result accept.
- `rsp_data_o` out DATA_W: result, shared by all requesters.
- `mem_req_o` out 1: read request.
- `mem_addr_o` out ADDR_W: read address.
- `mem_gnt_i` in 1: request accepted.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in DATA_W: read data.
- `acc_start_o` out 1: engine start, level.
- `acc_data_o` out DATA_W: engine operand word.
- `acc_data_i` in DATA_W: engine cumulative total.
- `acc_done_i` in 1: engine done, level.
- `busy_o` out 1: not IDLE.
- `owner_o` out max(1,$clog2(NUM_REQ)): granted requester index.

## Operation
FSM states: IDLE, FETCH, WAIT_DATA, KICK, RELEASE, RESP.

- **IDLE:** pick the first requester with `req_valid_i` high, searching from `rr_ptr` upward with wrap.
  - Assert that requester's `req_ready_o` combinationally.
  - Latch its address, length and `owner_o`. Set `base_q <= total_q`.
  - Set `rr_ptr <= grant+1`, modulo NUM_REQ.
  - Next state is FETCH if len≠0, else RESP with result 0.
- **FETCH:** hold `mem_req_o`=1 with `mem_addr_o`=current address until `mem_gnt_i`, then go to WAIT_DATA.
  - A `mem_rvalid_i` arriving in the same cycle as the grant is accepted.
- **WAIT_DATA:** on `mem_rvalid_i`, register `mem_rdata_i` into `acc_data_o`, then go to KICK.
- **KICK:** hold `acc_start_o`=1 and `acc_data_o` stable until `acc_done_i`=1.
  - Then capture `total_q <= acc_data_i`, drop `acc_start_o`, go to RELEASE.
- **RELEASE:** `acc_start_o`=0; wait for `acc_done_i`=0.
  - Then decrement remaining length and add DATA_W/8 to the address.
  - Next state is FETCH if remaining≠0, else RESP.
- **RESP:** `rsp_valid_o[owner]`=1 with `rsp_data_o = total_q - base_q` (mod 2^DATA_W) until `rsp_ready_i[owner]`, then go to IDLE.

Arithmetic and reset rules:
- The engine never clears its total, so results are always differences. Wrap of the cumulative total is handled by modular subtraction.
- Address wraps modulo 2^ADDR_W.
- `total_q` resets to 0, matching the engine's reset value.
- The engine and scheduler share the reset domain, with inverted polarity.
- Reset mid-job aborts the job with no response. All state is cleared and `rr_ptr`=0.

## Timing
- All outputs are registered except `req_ready_o`, which is decoded from state and the arbitration result.
- Reset values are 0 for every output: `req_ready_o`, `rsp_valid_o`, `rsp_data_o`, `mem_req_o`, `mem_addr_o`, `acc_start_o`, `acc_data_o`, `busy_o`, `owner_o`.
- Per-word latency with zero-wait memory and engine: IDLE/RELEASE→FETCH 1, FETCH 1, WAIT_DATA 1, KICK 2 (engine registers done), RELEASE 2. That is 6–7 cycles per word.
- Job accept to `rsp_valid_o` with len=0: 1 cycle.
- A new request is accepted in the cycle after a response handshake, never in the same cycle.
- `req_valid_i` may drop without acceptance; the grant is evaluated each IDLE cycle.
- A requester may hold `req_valid_i` during its own RESP; it waits for the next IDLE.
- A stuck-high `acc_done_i` in KICK/RELEASE has no timeout; the FSM stalls by design.

## Structure
- Shared package or `constants.vh` holds: FSM state encoding localparams, the `ACC_SCHED_*` default widths, and the bytes-per-word constant derived from `` `FE_DATA_W ``.
- One sub-module, `rr_arbiter`: parameterised by N; inputs req vector and pointer; outputs one-hot grant, index and any-valid.
- The FSM, fetch datapath and result subtractor stay in the top module.

## Test plan
- **Single job:** req0 addr 0x100, len 2; mem words 0x04030201 and 0x06060606 (engine adds 2 then 4).
  - Required: `rsp_data_o`=6 on `rsp_valid_o`=2'b01.
  - Required: `mem_addr_o` sequence 0x100, 0x104.
- **Back-to-back results:** second job on req1 with len 1, word 0x01010101.
  - Required: `rsp_data_o`=0, although `acc_data_i` reads 6.
- **Round-robin:** both requesters hold valid continuously.
  - Required: grants alternate 0,1,0,1; `owner_o` matches each response.
- **Zero-length job:** len=0.
  - Required: `rsp_valid_o` one cycle after accept, data 0, no `mem_req_o` or `acc_start_o` pulses.
- **Stalls:** `mem_gnt_i` delayed 3 cycles, `rsp_ready_i` delayed 4 cycles.
  - Required: `mem_addr_o`, `rsp_data_o` and `rsp_valid_o` held stable throughout.
  - Required: no new grant until `rsp_ready_i`.
- **Reset mid-operation:** assert `arst_ni`=0 during KICK of a 3-word job.
  - Required: all outputs 0 immediately.
  - Required: after release, a new job reports the correct count from base 0.

Source files
------------

// File: rtl/accel_job_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// accel_job_scheduler_pkg : shared widths, state encoding and helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif
`default_nettype none
package accel_job_scheduler_pkg;
   localparam int ACC_SCHED_NUM_REQ         = 2;
   localparam int ACC_SCHED_ADDR_W          = 32;
   localparam int ACC_SCHED_LEN_W           = 16;
   localparam int ACC_SCHED_DATA_W          = `FE_DATA_W;
   localparam int ACC_SCHED_BYTES_PER_WORD  = `FE_DATA_W / 8;

   localparam logic [2:0] c_ST_IDLE      = 3'd0;
   localparam logic [2:0] c_ST_FETCH     = 3'd1;
   localparam logic [2:0] c_ST_WAIT_DATA = 3'd2;
   localparam logic [2:0] c_ST_KICK      = 3'd3;
   localparam logic [2:0] c_ST_RELEASE   = 3'd4;
   localparam logic [2:0] c_ST_RESP      = 3'd5;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage
`default_nettype wire

// File: rtl/accel_job_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : first requester at or above the pointer wins, with wrap
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module rr_arbiter
   import accel_job_scheduler_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any_valid
);
   int               w_k;
   logic [IDX_W-1:0] w_k_idx;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      w_k       = 0;
      w_k_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_k     = (int'(ptr) + i) % N;
         w_k_idx = IDX_W'(w_k);
         if (!any_valid && req[w_k_idx]) begin
            any_valid      = 1'b1;
            grant[w_k_idx] = 1'b1;
            idx            = w_k_idx;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/accel_job_scheduler.sv
// ----------------------------------------------------------------------------
// accel_job_scheduler : shares one map/reduce engine between NUM_REQ requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module accel_job_scheduler
   import accel_job_scheduler_pkg::*;
#(
   parameter int NUM_REQ = ACC_SCHED_NUM_REQ,
   parameter int ADDR_W  = ACC_SCHED_ADDR_W,
   parameter int LEN_W   = ACC_SCHED_LEN_W,
   parameter int DATA_W  = ACC_SCHED_DATA_W
) (
   input  logic                            clk_i,
   input  logic                            arst_ni,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*ADDR_W-1:0]       req_addr_i,
   input  logic [NUM_REQ*LEN_W-1:0]        req_len_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   input  logic [NUM_REQ-1:0]              rsp_ready_i,
   output logic [DATA_W-1:0]               rsp_data_o,
   output logic                            mem_req_o,
   output logic [ADDR_W-1:0]               mem_addr_o,
   input  logic                            mem_gnt_i,
   input  logic                            mem_rvalid_i,
   input  logic [DATA_W-1:0]               mem_rdata_i,
   output logic                            acc_start_o,
   output logic [DATA_W-1:0]               acc_data_o,
   input  logic [DATA_W-1:0]               acc_data_i,
   input  logic                            acc_done_i,
   output logic                            busy_o,
   output logic [idx_width(NUM_REQ)-1:0]   owner_o
);
   localparam int                IDX_W       = idx_width(NUM_REQ);
   localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(DATA_W / 8);

   logic [2:0]         r_state;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [ADDR_W-1:0]  r_addr;
   logic [LEN_W-1:0]   r_len;
   logic [DATA_W-1:0]  r_base;
   logic [DATA_W-1:0]  r_total;
   logic [DATA_W-1:0]  r_acc_data;
   logic [DATA_W-1:0]  r_rsp_data;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic               r_mem_req;
   logic               r_acc_start;
   logic               r_busy;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_any;
   logic [IDX_W-1:0]   w_ptr_next;
   logic [LEN_W-1:0]   w_len_dec;
   logic [NUM_REQ-1:0] w_owner_onehot;
   logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
   logic [LEN_W-1:0]   w_len_arr  [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
      assign w_len_arr[gi]  = req_len_i[gi*LEN_W +: LEN_W];
   end

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req       (req_valid_i),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .idx       (w_grant_idx),
      .any_valid (w_any)
   );

   assign w_ptr_next     = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
   assign w_len_dec      = r_len - LEN_W'(1);
   assign w_owner_onehot = NUM_REQ'(1) << r_owner;

   // Gated by reset so the only combinational output is also 0 while in reset.
   assign req_ready_o = (r_state == c_ST_IDLE && arst_ni) ? w_grant : '0;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign mem_req_o   = r_mem_req;
   assign mem_addr_o  = r_addr;
   assign acc_start_o = r_acc_start;
   assign acc_data_o  = r_acc_data;
   assign busy_o      = r_busy;
   assign owner_o     = r_owner;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state     <= c_ST_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_base      <= '0;
         r_total     <= '0;
         r_acc_data  <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= '0;
         r_mem_req   <= 1'b0;
         r_acc_start <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_any) begin
                  r_owner  <= w_grant_idx;
                  r_addr   <= w_addr_arr[w_grant_idx];
                  r_len    <= w_len_arr[w_grant_idx];
                  r_base   <= r_total;
                  r_rr_ptr <= w_ptr_next;
                  r_busy   <= 1'b1;
                  if (w_len_arr[w_grant_idx] != '0) begin
                     r_mem_req <= 1'b1;
                     r_state   <= c_ST_FETCH;
                  end else begin
                     r_rsp_valid <= w_grant;
                     r_rsp_data  <= '0;
                     r_state     <= c_ST_RESP;
                  end
               end
            end
            c_ST_FETCH: begin
               if (mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  if (mem_rvalid_i) begin
                     r_acc_data  <= mem_rdata_i;
                     r_acc_start <= 1'b1;
                     r_state     <= c_ST_KICK;
                  end else begin
                     r_state <= c_ST_WAIT_DATA;
                  end
               end
            end
            c_ST_WAIT_DATA: begin
               if (mem_rvalid_i) begin
                  r_acc_data  <= mem_rdata_i;
                  r_acc_start <= 1'b1;
                  r_state     <= c_ST_KICK;
               end
            end
            c_ST_KICK: begin
               if (acc_done_i) begin
                  r_total     <= acc_data_i;
                  r_acc_start <= 1'b0;
                  r_state     <= c_ST_RELEASE;
               end
            end
            c_ST_RELEASE: begin
               if (!acc_done_i) begin
                  r_len  <= w_len_dec;
                  r_addr <= r_addr + c_ADDR_STEP;
                  if (w_len_dec != '0) begin
                     r_mem_req <= 1'b1;
                     r_state   <= c_ST_FETCH;
                  end else begin
                     // Engine total is cumulative; modular difference survives wrap.
                     r_rsp_valid <= w_owner_onehot;
                     r_rsp_data  <= r_total - r_base;
                     r_state     <= c_ST_RESP;
                  end
               end
            end
            c_ST_RESP: begin
               if (rsp_ready_i[r_owner]) begin
                  r_rsp_valid <= '0;
                  r_busy      <= 1'b0;
                  r_state     <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_accel_job_scheduler.sv
// ----------------------------------------------------------------------------
// tb_accel_job_scheduler : randomized self-checking bench with engine/memory models
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module tb_accel_job_scheduler;
   import accel_job_scheduler_pkg::*;

   localparam int NR = 2;
   localparam int AW = 32;
   localparam int LW = 16;
   localparam int DW = 32;
   localparam int IW = 1;

   logic clk = 1'b0;
   logic arst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*LW-1:0] req_len;
   logic [DW-1:0]    rsp_data, mem_rdata, acc_operand, acc_total;
   logic             mem_req, mem_gnt, mem_rvalid, acc_start, acc_done, busy;
   logic [AW-1:0]    mem_addr;
   logic [IW-1:0]    owner;

   int vectors = 0;
   int miscompares = 0;

   int            gnt_delay = 0;
   bit            rv_same = 1'b0;
   int            wait_cnt;
   logic          r_rv;
   logic [31:0]   r_rdata;
   logic [31:0]   addr_log [$];
   bit [31:0]     mem_ovr [bit [31:0]];
   int            addr_glitch = 0;
   int            mem_req_cycles = 0;
   int            acc_start_cycles = 0;
   logic          mon_stalled = 1'b0;
   logic [31:0]   mon_addr = '0;
   int            model_ptr = 0;

   accel_job_scheduler #(
      .NUM_REQ (NR), .ADDR_W (AW), .LEN_W (LW), .DATA_W (DW)
   ) dut (
      .clk_i        (clk),
      .arst_ni      (arst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_len_i    (req_len),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_data_o   (rsp_data),
      .mem_req_o    (mem_req),
      .mem_addr_o   (mem_addr),
      .mem_gnt_i    (mem_gnt),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata),
      .acc_start_o  (acc_start),
      .acc_data_o   (acc_operand),
      .acc_data_i   (acc_total),
      .acc_done_i   (acc_done),
      .busy_o       (busy),
      .owner_o      (owner)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return (a * 32'h9E3779B1) ^ 32'h3C6EF372;
   endfunction

   // Engine operation: count of bytes whose value is even.
   function automatic logic [31:0] even_bytes(input logic [31:0] w);
      int n = 0;
      for (int b = 0; b < 4; b++) if (w[8*b] == 1'b0) n++;
      return 32'(n);
   endfunction

   function automatic logic [31:0] exp_result(input logic [31:0] a, input int len);
      logic [31:0] s = '0;
      for (int i = 0; i < len; i++) s = s + even_bytes(mem_word(a + 32'(4*i)));
      return s;
   endfunction

   assign mem_gnt    = mem_req && (wait_cnt >= gnt_delay);
   assign mem_rvalid = rv_same ? mem_gnt : r_rv;
   assign mem_rdata  = rv_same ? mem_word(mem_addr) : r_rdata;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wait_cnt <= 0;
         r_rv     <= 1'b0;
         r_rdata  <= '0;
      end else begin
         wait_cnt <= (mem_req && !mem_gnt) ? wait_cnt + 1 : 0;
         r_rv     <= mem_gnt && !rv_same;
         r_rdata  <= mem_word(mem_addr);
         if (mem_gnt) addr_log.push_back(mem_addr);
      end
   end

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         acc_done  <= 1'b0;
         acc_total <= '0;
      end else if (acc_start && !acc_done) begin
         acc_done  <= 1'b1;
         acc_total <= acc_total + even_bytes(acc_operand);
      end else if (!acc_start && acc_done) begin
         acc_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (arst_n) begin
         if (mon_stalled && (mem_addr !== mon_addr || mem_req !== 1'b1)) addr_glitch <= addr_glitch + 1;
         if (mem_req)   mem_req_cycles   <= mem_req_cycles + 1;
         if (acc_start) acc_start_cycles <= acc_start_cycles + 1;
      end
      mon_stalled <= arst_n && mem_req && !mem_gnt;
      mon_addr    <= mem_addr;
   end

   // Drives one job on requester r and reports what the response looked like.
   task automatic do_job(input int r, input logic [31:0] a, input logic [15:0] l,
                         input int rsp_delay, input bit other_valid,
                         output logic [31:0] data, output logic [NR-1:0] vld_seen,
                         output logic [IW-1:0] own_seen, output int lat,
                         output bit held, output bit early_grant, output bit tmo);
      int cnt;
      tmo = 1'b0; held = 1'b1; early_grant = 1'b0; lat = 0;
      data = '0; vld_seen = '0; own_seen = '0;
      @(negedge clk);
      req_addr[r*AW +: AW] = a;
      req_len[r*LW +: LW]  = l;
      req_valid[r]         = 1'b1;
      cnt = 0;
      #1;
      while (req_ready[r] !== 1'b1 && cnt < 200) begin @(negedge clk); #1; cnt++; end
      if (cnt >= 200) begin tmo = 1'b1; req_valid[r] = 1'b0; return; end
      model_ptr = (r + 1) % NR;
      @(negedge clk);
      req_valid[r] = 1'b0;
      cnt = 0;
      while (rsp_valid[r] !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
      if (cnt >= 2000) begin tmo = 1'b1; return; end
      lat = cnt; data = rsp_data; vld_seen = rsp_valid; own_seen = owner;
      if (other_valid) begin
         req_len[((r+1)%NR)*LW +: LW] = '0;
         req_valid[(r+1)%NR] = 1'b1;
      end
      repeat (rsp_delay) begin
         @(negedge clk);
         if (rsp_data !== data || rsp_valid !== vld_seen) held = 1'b0;
         if (req_ready !== '0) early_grant = 1'b1;
      end
      if (other_valid) req_valid[(r+1)%NR] = 1'b0;
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready[r] = 1'b0;
   endtask

   task automatic test_reset();
      #2 arst_n = 1'b0;
      req_len = {16'd3, 16'd3};
      req_valid = 2'b11;
      #1;
      vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
      vectors++; if ({mem_req, acc_start, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_ctrl: got %b want 000", {mem_req, acc_start, busy}); end
      vectors++; if (rsp_valid !== '0 || rsp_data !== '0) begin miscompares++; $display("FAIL rst_rsp: got %b/%h want 00/0", rsp_valid, rsp_data); end
      vectors++; if (mem_addr !== '0 || acc_operand !== '0 || owner !== '0) begin miscompares++; $display("FAIL rst_data: got %h/%h/%h want 0", mem_addr, acc_operand, owner); end
      repeat (3) @(negedge clk);
      req_valid = '0;
      arst_n = 1'b1;
      model_ptr = 0;
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got busy=%b req=%b want 0", busy, mem_req); end
   endtask

   task automatic test_single_job();
      logic [31:0] d; logic [NR-1:0] v; logic [IW-1:0] o; int lat; bit h, e, t;
      mem_ovr[32'h100] = 32'h04030201;
      mem_ovr[32'h104] = 32'h06060606;
      addr_log.delete();
      do_job(0, 32'h100, 16'd2, 0, 1'b0, d, v, o, lat, h, e, t);
      vectors++; if (t) begin miscompares++; $display("FAIL single_timeout: got 1 want 0"); end
      vectors++; if (d !== 32'd6) begin miscompares++; $display("FAIL single_data: got %h want 6", d); end
      vectors++; if (v !== 2'b01) begin miscompares++; $display("FAIL single_valid: got %b want 01", v); end
      vectors++;
      if (addr_log.size() != 2 || addr_log[0] !== 32'h100 || addr_log[1] !== 32'h104) begin
         miscompares++;
         $display("FAIL single_addrs: got %0d addrs first %h want 100,104", addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'hx);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [NR-1:0] v; logic [IW-1:0] o; int lat; bit h, e, t;
      mem_ovr[32'h200] = 32'h01010101;
      do_job(1, 32'h200, 16'd1, 0, 1'b0, d, v, o, lat, h, e, t);
      vectors++; if (t) begin miscompares++; $display("FAIL b2b_timeout: got 1 want 0"); end
      vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL b2b_data: got %h want 0", d); end
      vectors++; if (v !== 2'b10 || o !== 1'b1) begin miscompares++; $display("FAIL b2b_owner: got %b/%b want 10/1", v, o); end
   endtask

   task automatic test_round_robin();
      logic [31:0] a [NR];
      int cnt, g, expg;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         a[i] = $urandom & 32'hFFFF_FFFC;
         req_addr[i*AW +: AW] = a[i];
         req_len[i*LW +: LW]  = 16'd1;
      end
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cnt = 0; #1;
         while (req_ready === '0 && cnt < 200) begin @(negedge clk); #1; cnt++; end
         g = req_ready[1] ? 1 : 0;
         expg = model_ptr;
         vectors++; if (req_ready !== 2'(1 << expg)) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 2'(1 << expg)); end
         model_ptr = (g + 1) % NR;
         @(negedge clk);
         cnt = 0;
         while (rsp_valid === '0 && cnt < 200) begin @(negedge clk); cnt++; end
         vectors++; if (owner !== IW'(g) || rsp_valid !== 2'(1 << g)) begin miscompares++; $display("FAIL rr_owner%0d: got %b/%b want %0d", k, owner, rsp_valid, g); end
         vectors++; if (rsp_data !== exp_result(a[g], 1)) begin miscompares++; $display("FAIL rr_data%0d: got %h want %h", k, rsp_data, exp_result(a[g], 1)); end
         rsp_ready = rsp_valid;
         @(negedge clk);
         rsp_ready = '0;
      end
      req_valid = '0;
   endtask

   task automatic test_zero_length();
      logic [31:0] d; logic [NR-1:0] v; logic [IW-1:0] o; int lat, mr0, as0; bit h, e, t;
      mr0 = mem_req_cycles; as0 = acc_start_cycles;
      do_job(0, $urandom & 32'hFFFF_FFFC, 16'd0, 0, 1'b0, d, v, o, lat, h, e, t);
      vectors++; if (t || lat != 0) begin miscompares++; $display("FAIL zero_latency: got %0d extra cycles (tmo %0b) want 0", lat, t); end
      vectors++; if (d !== 32'd0 || v !== 2'b01) begin miscompares++; $display("FAIL zero_data: got %h/%b want 0/01", d, v); end
      vectors++; if (mem_req_cycles != mr0 || acc_start_cycles != as0) begin miscompares++; $display("FAIL zero_pulses: got %0d/%0d want 0/0", mem_req_cycles - mr0, acc_start_cycles - as0); end
   endtask

   task automatic test_stalls();
      logic [31:0] d, a; logic [NR-1:0] v; logic [IW-1:0] o; int lat, g0; bit h, e, t;
      a = $urandom & 32'hFFFF_FFFC;
      gnt_delay = 3;
      g0 = addr_glitch;
      addr_log.delete();
      do_job(0, a, 16'd2, 4, 1'b1, d, v, o, lat, h, e, t);
      gnt_delay = 0;
      vectors++; if (t) begin miscompares++; $display("FAIL stall_timeout: got 1 want 0"); end
      vectors++; if (d !== exp_result(a, 2)) begin miscompares++; $display("FAIL stall_data: got %h want %h", d, exp_result(a, 2)); end
      vectors++; if (!h) begin miscompares++; $display("FAIL stall_rsp_held: got changed want stable"); end
      vectors++; if (e) begin miscompares++; $display("FAIL stall_early_grant: got grant want none"); end
      vectors++; if (addr_glitch != g0) begin miscompares++; $display("FAIL stall_addr_held: got %0d glitches want 0", addr_glitch - g0); end
      vectors++; if (addr_log.size() != 2 || addr_log[1] !== a + 32'd4) begin miscompares++; $display("FAIL stall_addrs: got %0d addrs want 2", addr_log.size()); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, b; logic [NR-1:0] v; logic [IW-1:0] o; int lat, cnt; bit h, e, t;
      @(negedge clk);
      req_addr[0 +: AW] = $urandom & 32'hFFFF_FFFC;
      req_len[0 +: LW]  = 16'd3;
      req_valid[0] = 1'b1;
      cnt = 0; #1;
      while (req_ready[0] !== 1'b1 && cnt < 200) begin @(negedge clk); #1; cnt++; end
      @(negedge clk);
      req_valid[0] = 1'b0;
      cnt = 0;
      while (acc_start !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
      vectors++; if (acc_start !== 1'b1) begin miscompares++; $display("FAIL rmid_kick: got %b want 1", acc_start); end
      arst_n = 1'b0;
      req_valid = 2'b01;
      #1;
      vectors++;
      if ({req_ready, rsp_valid, mem_req, acc_start, busy, owner} !== '0 || rsp_data !== '0 || mem_addr !== '0 || acc_operand !== '0) begin
         miscompares++;
         $display("FAIL rmid_outputs: got rdy=%b vld=%b req=%b st=%b busy=%b addr=%h want all 0", req_ready, rsp_valid, mem_req, acc_start, busy, mem_addr);
      end
      repeat (2) @(negedge clk);
      req_valid = '0;
      arst_n = 1'b1;
      model_ptr = 0;
      b = $urandom & 32'hFFFF_FFFC;
      do_job(1, b, 16'd2, 1, 1'b0, d, v, o, lat, h, e, t);
      vectors++; if (t || d !== exp_result(b, 2) || o !== 1'b1) begin miscompares++; $display("FAIL rmid_after: got %h owner %b want %h owner 1", d, o, exp_result(b, 2)); end
   endtask

   task automatic test_random();
      logic [31:0] d, a; logic [NR-1:0] v; logic [IW-1:0] o; int lat, r, l; bit h, e, t;
      for (int k = 0; k < 20; k++) begin
         r = int'($urandom_range(0, NR - 1));
         l = int'($urandom_range(0, 4));
         a = $urandom & 32'hFFFF_FFFC;
         gnt_delay = int'($urandom_range(0, 2));
         rv_same = 1'($urandom);
         do_job(r, a, 16'(l), int'($urandom_range(0, 3)), 1'b0, d, v, o, lat, h, e, t);
         vectors++;
         if (t || d !== exp_result(a, l) || o !== IW'(r) || v !== 2'(1 << r)) begin
            miscompares++;
            $display("FAIL rand%0d: got %h owner %b vld %b want %h owner %0d", k, d, o, v, exp_result(a, l), r);
         end
      end
      gnt_delay = 0;
      rv_same = 1'b0;
   endtask

   initial begin
      req_valid = '0; rsp_ready = '0; req_addr = '0; req_len = '0;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_round_robin();
      test_zero_length();
      test_stalls();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
